axil_slave_demux: RTL and testbench

1-master-to-M-slave AXI-Lite demultiplexer, the fan-out end of the interconnect. The round-robin arbitration stage grants one master, and this block routes that master onto one of M slave ports. It decodes AW/AR addresses to a slave index, forwards each request, and routes B/R responses back. Unmapped addresses are answered internally with DECERR.

---
 rtl/axil_slave_demux_if.sv | 39 +++
 rtl/axil_slave_demux.sv | 183 ++++++++++++++++++
 tb/tb_axil_slave_demux.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_slave_demux_if.sv
// AXI-Lite channel bundle carrying N parallel links; N=1 for the master side,
// N=M for the fanned-out slave side.
interface axil_slave_demux_if #(
    parameter int unsigned N      = 1,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [N*ADDR_W-1:0] awaddr;
    logic [N-1:0]        awvalid;
    logic [N-1:0]        awready;
    logic [N*DATA_W-1:0] wdata;
    logic [N*STRB_W-1:0] wstrb;
    logic [N-1:0]        wvalid;
    logic [N-1:0]        wready;
    logic [N*2-1:0]      bresp;
    logic [N-1:0]        bvalid;
    logic [N-1:0]        bready;
    logic [N*ADDR_W-1:0] araddr;
    logic [N-1:0]        arvalid;
    logic [N-1:0]        arready;
    logic [N*DATA_W-1:0] rdata;
    logic [N*2-1:0]      rresp;
    logic [N-1:0]        rvalid;
    logic [N-1:0]        rready;

    // Request issuer: drives address/data/valid, consumes responses.
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    // Request target: drives ready and responses.
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_slave_demux.sv
// 1-to-M AXI-Lite demultiplexer: decodes AW/AR into fixed 2^REGION_W windows,
// forwards one request per path and answers unmapped addresses with DECERR.
module axil_slave_demux #(
    parameter int unsigned       M         = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h4000_0000),
    parameter int unsigned       REGION_W  = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axil_slave_demux_if.slave    m,
    axil_slave_demux_if.master   s
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_ERR} r_state_t;

    // Below-base addresses are rejected before the subtraction can wrap.
    function automatic logic dec_hit(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> REGION_W) < ADDR_W'(M));
    endfunction

    function automatic logic [IDX_W-1:0] dec_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> REGION_W);
    endfunction

    w_state_t            w_state, w_next;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic [STRB_W-1:0]   w_strb;
    logic [IDX_W-1:0]    w_idx;
    logic [M-1:0]        aw_vld, wd_vld;
    logic                w_hit_c, m_awready_c, m_bvalid_c;
    logic [1:0]          m_bresp_c;
    logic [M-1:0]        s_bready_c;

    r_state_t            r_state, r_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [IDX_W-1:0]    r_idx;
    logic [M-1:0]        ar_vld;
    logic                r_hit_c, m_arready_c, m_rvalid_c;
    logic [1:0]          m_rresp_c;
    logic [DATA_W-1:0]   m_rdata_c;
    logic [M-1:0]        s_rready_c;

    // Write path next-state and response muxing.
    always_comb begin
        w_next      = w_state;
        m_awready_c = 1'b0;
        m_bvalid_c  = 1'b0;
        m_bresp_c   = 2'b00;
        s_bready_c  = '0;
        w_hit_c     = dec_hit(m.awaddr);
        case (w_state)
            W_IDLE: begin
                m_awready_c = m.awvalid[0] & m.wvalid[0];
                if (m_awready_c) w_next = w_hit_c ? W_FWD : W_ERR;
            end
            W_FWD: begin
                if (((aw_vld & ~s.awready) == '0) && ((wd_vld & ~s.wready) == '0))
                    w_next = W_RESP;
            end
            W_RESP: begin
                m_bvalid_c        = s.bvalid[w_idx];
                m_bresp_c         = s.bresp[{w_idx, 1'b0} +: 2];
                s_bready_c[w_idx] = m.bready[0];
                if (m_bvalid_c && m.bready[0]) w_next = W_IDLE;
            end
            W_ERR: begin
                m_bvalid_c = 1'b1;
                m_bresp_c  = 2'b11;
                if (m.bready[0]) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Request capture; each slave-side valid clears on its own handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_addr <= '0;
            w_data <= '0;
            w_strb <= '0;
            w_idx  <= '0;
            aw_vld <= '0;
            wd_vld <= '0;
        end else if (m_awready_c) begin
            w_addr <= m.awaddr;
            w_data <= m.wdata;
            w_strb <= m.wstrb;
            w_idx  <= dec_idx(m.awaddr);
            aw_vld <= w_hit_c ? (M'(1) << dec_idx(m.awaddr)) : '0;
            wd_vld <= w_hit_c ? (M'(1) << dec_idx(m.awaddr)) : '0;
        end else begin
            aw_vld <= aw_vld & ~s.awready;
            wd_vld <= wd_vld & ~s.wready;
        end
    end

    // Read path next-state and response muxing.
    always_comb begin
        r_next      = r_state;
        m_arready_c = 1'b0;
        m_rvalid_c  = 1'b0;
        m_rresp_c   = 2'b00;
        m_rdata_c   = '0;
        s_rready_c  = '0;
        r_hit_c     = dec_hit(m.araddr);
        case (r_state)
            R_IDLE: begin
                m_arready_c = m.arvalid[0];
                if (m_arready_c) r_next = r_hit_c ? R_FWD : R_ERR;
            end
            R_FWD: begin
                if ((ar_vld & ~s.arready) == '0) r_next = R_RESP;
            end
            R_RESP: begin
                m_rvalid_c        = s.rvalid[r_idx];
                m_rresp_c         = s.rresp[{r_idx, 1'b0} +: 2];
                m_rdata_c         = s.rdata[DATA_W*r_idx +: DATA_W];
                s_rready_c[r_idx] = m.rready[0];
                if (m_rvalid_c && m.rready[0]) r_next = R_IDLE;
            end
            R_ERR: begin
                m_rvalid_c = 1'b1;
                m_rresp_c  = 2'b11;
                if (m.rready[0]) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_idx  <= '0;
            ar_vld <= '0;
        end else if (m_arready_c) begin
            r_addr <= m.araddr;
            r_idx  <= dec_idx(m.araddr);
            ar_vld <= r_hit_c ? (M'(1) << dec_idx(m.araddr)) : '0;
        end else begin
            ar_vld <= ar_vld & ~s.arready;
        end
    end

    assign m.awready = m_awready_c;
    assign m.wready  = m_awready_c;
    assign m.bvalid  = m_bvalid_c;
    assign m.bresp   = m_bresp_c;
    assign m.arready = m_arready_c;
    assign m.rvalid  = m_rvalid_c;
    assign m.rresp   = m_rresp_c;
    assign m.rdata   = m_rdata_c;

    // Every slave sees the same payload; only the selected valid is raised.
    assign s.awaddr  = {M{w_addr}};
    assign s.awvalid = aw_vld;
    assign s.wdata   = {M{w_data}};
    assign s.wstrb   = {M{w_strb}};
    assign s.wvalid  = wd_vld;
    assign s.bready  = s_bready_c;
    assign s.araddr  = {M{r_addr}};
    assign s.arvalid = ar_vld;
    assign s.rready  = s_rready_c;
endmodule

// File: tb/tb_axil_slave_demux.sv
// Scoreboard bench for axil_slave_demux: behavioural slaves with programmable
// wait states, expected routing/responses queued at issue and checked on output.
module tb_axil_slave_demux;
    localparam int unsigned M  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_slave_demux_if #(.N(1), .ADDR_W(AW), .DATA_W(DW)) m_if ();
    axil_slave_demux_if #(.N(M), .ADDR_W(AW), .DATA_W(DW)) s_if ();

    axil_slave_demux #(
        .M(M), .ADDR_W(AW), .DATA_W(DW),
        .BASE_ADDR(32'h4000_0000), .REGION_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m(m_if), .s(s_if)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit tb_map(input logic [31:0] a, output logic [1:0] idx);
        logic [31:0] off;
        idx = 2'd0;
        if (a < 32'h4000_0000) return 1'b0;
        off = a - 32'h4000_0000;
        if ((off >> 12) >= 32'd4) return 1'b0;
        idx = off[13:12];
        return 1'b1;
    endfunction

    logic [33:0] exp_aw[$];
    logic [37:0] exp_w[$];
    logic [1:0]  exp_b[$];
    logic [33:0] exp_ar[$];
    logic [33:0] exp_r[$];

    int          aw_dly[M] = '{default: 0};
    int          w_dly[M]  = '{default: 0};
    int          ar_dly[M] = '{default: 0};
    int          r_dly[M]  = '{default: 0};
    logic [31:0] slv_rdata[M];

    // Behavioural slaves: ready after N valid cycles, response after both beats.
    int       aw_cnt[M], w_cnt[M], ar_cnt[M], r_cnt[M];
    bit [M-1:0] aw_got, w_got, ar_got, b_done, r_done;
    initial begin
        s_if.awready = '0; s_if.wready = '0; s_if.bvalid = '0; s_if.bresp = '0;
        s_if.arready = '0; s_if.rvalid = '0; s_if.rresp = '0; s_if.rdata = '0;
        aw_got = '0; w_got = '0; ar_got = '0; b_done = '0; r_done = '0;
        for (int i = 0; i < M; i++) begin
            aw_cnt[i] = 0; w_cnt[i] = 0; ar_cnt[i] = 0; r_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_got = '0; w_got = '0; ar_got = '0; b_done = '0; r_done = '0;
                s_if.awready = '0; s_if.wready = '0; s_if.arready = '0;
                s_if.bvalid = '0; s_if.rvalid = '0;
                for (int i = 0; i < M; i++) begin
                    aw_cnt[i] = 0; w_cnt[i] = 0; ar_cnt[i] = 0; r_cnt[i] = 0;
                end
            end else begin
                for (int i = 0; i < M; i++) begin
                    if (s_if.awvalid[i] && s_if.awready[i]) begin aw_got[i] = 1'b1; aw_cnt[i] = 0; end
                    if (s_if.wvalid[i] && s_if.wready[i])   begin w_got[i] = 1'b1;  w_cnt[i] = 0;  end
                    if (s_if.arvalid[i] && s_if.arready[i]) begin ar_got[i] = 1'b1; ar_cnt[i] = 0; r_cnt[i] = 0; end
                    if (s_if.bvalid[i] && s_if.bready[i])   b_done[i] = 1'b1;
                    if (s_if.rvalid[i] && s_if.rready[i])   r_done[i] = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < M; i++) begin
                s_if.rdata[i*DW +: DW] = slv_rdata[i];
                s_if.awready[i] = s_if.awvalid[i] && (aw_cnt[i] >= aw_dly[i]);
                if (s_if.awvalid[i]) aw_cnt[i]++;
                s_if.wready[i] = s_if.wvalid[i] && (w_cnt[i] >= w_dly[i]);
                if (s_if.wvalid[i]) w_cnt[i]++;
                s_if.arready[i] = s_if.arvalid[i] && (ar_cnt[i] >= ar_dly[i]);
                if (s_if.arvalid[i]) ar_cnt[i]++;
                if (b_done[i]) begin
                    s_if.bvalid[i] = 1'b0; b_done[i] = 1'b0; aw_got[i] = 1'b0; w_got[i] = 1'b0;
                end else if (aw_got[i] && w_got[i]) begin
                    s_if.bvalid[i] = 1'b1;
                end
                if (r_done[i]) begin
                    s_if.rvalid[i] = 1'b0; r_done[i] = 1'b0; ar_got[i] = 1'b0;
                end else if (ar_got[i]) begin
                    if (r_cnt[i] >= r_dly[i]) s_if.rvalid[i] = 1'b1;
                    else r_cnt[i]++;
                end
            end
        end
    end

    // Output monitors and timing probes.
    int       m_aw_cyc, s_aw_cyc, b_cyc, s0_aw_hs, s0_w_hs, aw0_hi, w0_hi;
    bit       s_aw_seen;
    logic [3:0] vmask;
    always @(negedge clk) begin
        logic [37:0] e;
        if (rst_n) begin
            for (int i = 0; i < M; i++) begin
                if (s_if.awvalid[i] && s_if.awready[i]) begin
                    if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                    else begin
                        e = {4'h0, exp_aw.pop_front()};
                        chk("aw_route", {2'(i), s_if.awaddr[i*AW +: AW]}, e);
                    end
                end
                if (s_if.wvalid[i] && s_if.wready[i]) begin
                    if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
                    else begin
                        e = exp_w.pop_front();
                        chk("w_route", {2'(i), s_if.wstrb[i*4 +: 4], s_if.wdata[i*DW +: DW]}, e);
                    end
                end
                if (s_if.arvalid[i] && s_if.arready[i]) begin
                    if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
                    else begin
                        e = {4'h0, exp_ar.pop_front()};
                        chk("ar_route", {2'(i), s_if.araddr[i*AW +: AW]}, e);
                    end
                end
            end
            if (m_if.bvalid[0] && m_if.bready[0]) begin
                b_cyc = cyc;
                if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                else chk("bresp", m_if.bresp, exp_b.pop_front());
            end
            if (m_if.rvalid[0] && m_if.rready[0]) begin
                if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
                else chk("rresp_rdata", {m_if.rresp, m_if.rdata}, exp_r.pop_front());
            end
            if (m_if.awvalid[0] && m_if.awready[0]) begin
                m_aw_cyc  = cyc;
                s_aw_seen = 1'b0;
            end
            if (!s_aw_seen && (s_if.awvalid != '0)) begin
                s_aw_cyc  = cyc;
                s_aw_seen = 1'b1;
            end
            if (s_if.awvalid[0]) aw0_hi++;
            if (s_if.wvalid[0])  w0_hi++;
            if (s_if.awvalid[0] && s_if.awready[0]) s0_aw_hs = cyc;
            if (s_if.wvalid[0] && s_if.wready[0])   s0_w_hs  = cyc;
            vmask = vmask | s_if.awvalid | s_if.wvalid | s_if.arvalid;
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        logic [1:0] ix;
        bit ok, done;
        ok = tb_map(a, ix);
        if (ok) begin
            exp_aw.push_back({ix, a});
            exp_w.push_back({ix, st, d});
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(2'b11);
        end
        @(posedge clk);
        #1;
        m_if.awaddr = a; m_if.wdata = d; m_if.wstrb = st;
        m_if.awvalid = 1'b1; m_if.wvalid = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            done = m_if.awready[0] && m_if.wready[0];
        end
        if (!done) chk("aw_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        m_if.awvalid = 1'b0; m_if.wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a);
        logic [1:0] ix;
        bit ok, done;
        ok = tb_map(a, ix);
        if (ok) begin
            exp_ar.push_back({ix, a});
            exp_r.push_back({2'b00, slv_rdata[ix]});
        end else begin
            exp_r.push_back({2'b11, 32'h0});
        end
        @(posedge clk);
        #1;
        m_if.araddr = a; m_if.arvalid = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            done = m_if.arready[0];
        end
        if (!done) chk("ar_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        m_if.arvalid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_b.size() == 0 && exp_r.size() == 0) break;
        end
        chk(tag, 64'(exp_b.size() + exp_r.size()), 0);
    endtask

    task automatic clear_probes();
        vmask = '0; aw0_hi = 0; w0_hi = 0; s_aw_seen = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < M; i++) slv_rdata[i] = 32'hA5A5_0000 | 32'(i);
        slv_rdata[1] = 32'h1234_5678;
        m_if.awaddr = '0; m_if.awvalid = '0; m_if.wdata = '0; m_if.wstrb = '0;
        m_if.wvalid = '0; m_if.bready = 1'b1; m_if.araddr = '0; m_if.arvalid = '0;
        m_if.rready = 1'b1;
        clear_probes();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_ready", {m_if.awready, m_if.wready, m_if.arready}, 0);
        chk("rst_m_valid", {m_if.bvalid, m_if.rvalid}, 0);
        chk("rst_m_resp", {m_if.bresp, m_if.rresp, m_if.rdata}, 0);
        chk("rst_s_valid", {s_if.awvalid, s_if.wvalid, s_if.arvalid}, 0);
        chk("rst_s_ready", {s_if.bready, s_if.rready}, 0);
        chk("rst_s_addr", s_if.awaddr[63:0], 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero-wait write to slave 2: check latency and routing mask.
        clear_probes();
        axi_write(32'h4000_2010, 32'hDEAD_BEEF, 4'hF);
        wait_idle("wr_s2_drain");
        chk("wr_s2_aw_lat", 64'(s_aw_cyc - m_aw_cyc), 1);
        chk("wr_s2_b_lat", 64'(b_cyc - m_aw_cyc), 2);
        chk("wr_s2_mask", vmask, 4'b0100);

        // Read from slave 1 with a slow data phase.
        clear_probes();
        r_dly[1] = 3;
        axi_read(32'h4000_1004);
        wait_idle("rd_s1_drain");
        chk("rd_s1_mask", vmask, 4'b0010);
        r_dly[1] = 0;

        // Unmapped write above the last window and read below the base.
        clear_probes();
        fork
            axi_write(32'h4000_4000, 32'h5555_AAAA, 4'hF);
            axi_read(32'h3FFF_FFFC);
        join
        wait_idle("decerr_drain");
        chk("decerr_mask", vmask, 4'b0000);

        // Slave 0 accepts AW immediately but W only after three stalls.
        clear_probes();
        w_dly[0] = 3;
        axi_write(32'h4000_0008, 32'hCAFE_F00D, 4'b0011);
        wait_idle("split_drain");
        chk("split_aw_hi", 64'(aw0_hi), 1);
        chk("split_w_hi", 64'(w0_hi), 4);
        chk("split_aw_hs", 64'(s0_aw_hs - m_aw_cyc), 1);
        chk("split_w_hs", 64'(s0_w_hs - m_aw_cyc), 4);
        chk("split_b_lat", 64'(b_cyc - m_aw_cyc), 5);
        w_dly[0] = 0;

        // Concurrent write (slave 3, bready held low) and read (slave 0).
        clear_probes();
        m_if.bready = 1'b0;
        fork
            axi_write(32'h4000_3000, 32'h0123_4567, 4'hF);
            axi_read(32'h4000_0100);
        join
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (exp_r.size() == 0) break;
        end
        chk("conc_rd_done", 64'(exp_r.size()), 0);
        chk("conc_b_pending", 64'(exp_b.size()), 1);
        fork
            axi_write(32'h4000_3004, 32'h89AB_CDEF, 4'b1100);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("conc_b_hold", {m_if.bvalid, m_if.bresp}, 3'b100);
                    chk("conc_aw_stall", m_if.awready, 0);
                end
                @(posedge clk);
                #1 m_if.bready = 1'b1;
            end
        join
        chk("b2b_accept", 64'(m_aw_cyc - b_cyc), 1);
        wait_idle("conc_drain");
        chk("conc_mask", vmask, 4'b1001);

        // Reset while the write path waits in the response state.
        m_if.bready = 1'b0;
        axi_write(32'h4000_2020, 32'h7777_1111, 4'hF);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m_if.bvalid[0]) break;
        end
        chk("rst_mid_bvalid", m_if.bvalid, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_b.delete();
        @(negedge clk);
        chk("rst_mid_m_out", {m_if.bvalid, m_if.rvalid, m_if.awready, m_if.arready}, 0);
        chk("rst_mid_s_valid", {s_if.awvalid, s_if.wvalid, s_if.arvalid, s_if.bready}, 0);
        chk("rst_mid_s_data", {s_if.awaddr[31:0], s_if.wdata[31:0]}, 0);
        m_if.bready = 1'b1;
        clear_probes();
        axi_write(32'h4000_2FFC, 32'h0BAD_CAFE, 4'b0101);
        wait_idle("post_rst_drain");
        chk("post_rst_b_lat", 64'(b_cyc - m_aw_cyc), 2);
        chk("post_rst_mask", vmask, 4'b0100);
        chk("sb_left", 64'(exp_aw.size() + exp_w.size() + exp_ar.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
